// File: rtl/dma_burst_ctrl.sv
// DMA burst controller: splits a word copy into INCR bursts that never cross 4 KB and
// stages each burst in a local buffer between read and write. Optional macro: DMA_RESP_ERR_EN.
module dma_burst_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_src,
    input  logic [ADDR_W-1:0] cfg_dst,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              irq_clr,
    output logic              busy,
    output logic              done_irq,
    output logic              err,
    output logic              rd_start,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        rd_len,
    input  logic              rdat_valid,
    input  logic [DATA_W-1:0] rdat,
    input  logic              rd_done,
    input  logic              rd_err,
    output logic              wr_start,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_len,
    output logic [DATA_W-1:0] wdat,
    input  logic              wdat_ready,
    input  logic              wr_done,
    input  logic              wr_err
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int PTR_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int DEPTH = 1 << PTR_W;

`ifdef DMA_RESP_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CALC    = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_WAIT = 3'd3,
        S_WR_REQ  = 3'd4,
        S_WR_WAIT = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // Words left before the next 4 KB page boundary for a word-aligned page offset.
    function automatic logic [12:0] w4k(input logic [11:0] off);
        logic [12:0] t;
        t   = 13'd4096 - {1'b0, off};
        w4k = t >> 2;
    endfunction

    // Burst size: the smallest of remaining words, buffer depth and both page limits.
    function automatic logic [CNT_W-1:0] calc_beats(
        input logic [LEN_W-1:0] rem,
        input logic [11:0]      s_off,
        input logic [11:0]      d_off
    );
        logic [31:0] m;
        m = 32'(rem);
        m = (32'(w4k(s_off)) < m) ? 32'(w4k(s_off)) : m;
        m = (32'(w4k(d_off)) < m) ? 32'(w4k(d_off)) : m;
        m = (32'(MAX_BURST) < m) ? 32'(MAX_BURST) : m;
        calc_beats = CNT_W'(m);
    endfunction

    state_t              state_r;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   src_r;
    logic [ADDR_W-1:0]   dst_r;
    logic [LEN_W-1:0]    remaining_r;
    logic [CNT_W-1:0]    beats_r;
    logic [CNT_W-1:0]    wptr_r;
    logic [PTR_W-1:0]    rptr_r;
    logic [PTR_W-1:0]    rptr_nxt_s;
    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic [CNT_W-1:0]    beats_s;
    logic [ADDR_W-1:0]   step_s;
    logic                rd_abort_s;
    logic                wr_abort_s;
    logic                rd_fin_s;
    logic                wr_fin_s;
    logic                unused_s;

    assign beats_s    = calc_beats(remaining_r, src_r[11:0], dst_r[11:0]);
    assign step_s     = ADDR_W'({beats_r, 2'b00});
    assign rd_fin_s   = (state_r == S_RD_WAIT) && rd_done;
    assign wr_fin_s   = (state_r == S_WR_WAIT) && wr_done;
    assign rd_abort_s = ERR_EN & rd_err;
    assign wr_abort_s = ERR_EN & wr_err;
    assign unused_s   = ^{cfg_src[1:0], cfg_dst[1:0], rd_err, wr_err};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            S_IDLE: begin
                if (cfg_start) begin
                    state_nxt = (cfg_len == {LEN_W{1'b0}}) ? S_DONE : S_CALC;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_CALC:   state_nxt = S_RD_REQ;
            S_RD_REQ: state_nxt = S_RD_WAIT;
            S_RD_WAIT: begin
                if (rd_done) begin
                    state_nxt = rd_abort_s ? S_DONE : S_WR_REQ;
                end else begin
                    state_nxt = S_RD_WAIT;
                end
            end
            S_WR_REQ: state_nxt = S_WR_WAIT;
            S_WR_WAIT: begin
                if (wr_done) begin
                    state_nxt = (wr_abort_s || (remaining_r == LEN_W'(beats_r))) ? S_DONE : S_CALC;
                end else begin
                    state_nxt = S_WR_WAIT;
                end
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Read pointer for the write phase, saturating on the last beat of the burst.
    always_comb begin
        rptr_nxt_s = rptr_r;
        if (state_r == S_WR_REQ) begin
            rptr_nxt_s = {PTR_W{1'b0}};
        end else if ((state_r == S_WR_WAIT) && wdat_ready &&
                     ((CNT_W'(rptr_r) + CNT_W'(1)) < beats_r)) begin
            rptr_nxt_s = rptr_r + PTR_W'(1);
        end else begin
            rptr_nxt_s = rptr_r;
        end
    end

    // Copy bookkeeping: addresses, remaining count, burst size and buffer pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_r       <= {ADDR_W{1'b0}};
            dst_r       <= {ADDR_W{1'b0}};
            remaining_r <= {LEN_W{1'b0}};
            beats_r     <= {CNT_W{1'b0}};
            wptr_r      <= {CNT_W{1'b0}};
            rptr_r      <= {PTR_W{1'b0}};
        end else begin
            rptr_r <= rptr_nxt_s;
            case (state_r)
                S_IDLE: begin
                    if (cfg_start && (cfg_len != {LEN_W{1'b0}})) begin
                        src_r       <= {cfg_src[ADDR_W-1:2], 2'b00};
                        dst_r       <= {cfg_dst[ADDR_W-1:2], 2'b00};
                        remaining_r <= cfg_len;
                    end
                end
                S_CALC:   beats_r <= beats_s;
                S_RD_REQ: wptr_r  <= {CNT_W{1'b0}};
                S_RD_WAIT: begin
                    if (rdat_valid && (wptr_r < beats_r)) begin
                        wptr_r <= wptr_r + CNT_W'(1);
                    end
                end
                S_WR_WAIT: begin
                    if (wr_done) begin
                        src_r       <= src_r + step_s;
                        dst_r       <= dst_r + step_s;
                        remaining_r <= remaining_r - LEN_W'(beats_r);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Burst buffer; contents are don't-care after reset so it carries none.
    always_ff @(posedge clk) begin
        if ((state_r == S_RD_WAIT) && rdat_valid && (wptr_r < beats_r)) begin
            mem_r[wptr_r[PTR_W-1:0]] <= rdat;
        end
    end

    // Registered outputs; wdat is loaded from the next read pointer so it always equals buf[rptr].
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done_irq <= 1'b0;
            err      <= 1'b0;
            rd_start <= 1'b0;
            rd_addr  <= {ADDR_W{1'b0}};
            rd_len   <= 4'd0;
            wr_start <= 1'b0;
            wr_addr  <= {ADDR_W{1'b0}};
            wr_len   <= 4'd0;
            wdat     <= {DATA_W{1'b0}};
        end else begin
            rd_start <= 1'b0;
            wr_start <= 1'b0;
            if (state_r == S_CALC) begin
                rd_start <= 1'b1;
                rd_addr  <= src_r;
                rd_len   <= 4'(beats_s - CNT_W'(1));
            end
            if (rd_fin_s && !rd_abort_s) begin
                wr_start <= 1'b1;
                wr_addr  <= dst_r;
                wr_len   <= 4'(beats_r - CNT_W'(1));
            end
            if ((state_r == S_WR_REQ) || (state_r == S_WR_WAIT)) begin
                wdat <= mem_r[rptr_nxt_s];
            end
            if ((state_r == S_IDLE) && cfg_start && (cfg_len != {LEN_W{1'b0}})) begin
                busy <= 1'b1;
            end else if (state_r == S_DONE) begin
                busy <= 1'b0;
            end
            if (state_r == S_DONE) begin
                done_irq <= 1'b1;
            end else if (irq_clr) begin
                done_irq <= 1'b0;
            end
            if ((rd_fin_s && rd_abort_s) || (wr_fin_s && wr_abort_s)) begin
                err <= 1'b1;
            end else if (irq_clr) begin
                err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dma_burst_ctrl.sv
// Bench for dma_burst_ctrl: table of copies against a zero-latency master model,
// plus hand sequences for zero length, ignored restart, mid-copy reset and response errors.
`timescale 1ns/1ps
module tb_dma_burst_ctrl;
    localparam int ADDR_W = 32, DATA_W = 32, LEN_W = 16, MAX_BURST = 16;
    localparam logic [31:0] KEY = 32'hC0DE_5A5A;

    logic clk = 1'b0;
    logic rst, cfg_start, irq_clr;
    logic [31:0] cfg_src, cfg_dst;
    logic [15:0] cfg_len;
    logic busy, done_irq, err, rd_start, wr_start;
    logic [31:0] rd_addr, wr_addr, wdat, rdat;
    logic [3:0] rd_len, wr_len;
    logic rdat_valid, rd_done, rd_err, wdat_ready, wr_done, wr_err;

    always #5 clk = ~clk;

    dma_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_src(cfg_src), .cfg_dst(cfg_dst),
        .cfg_len(cfg_len), .irq_clr(irq_clr), .busy(busy), .done_irq(done_irq), .err(err),
        .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len), .rdat_valid(rdat_valid),
        .rdat(rdat), .rd_done(rd_done), .rd_err(rd_err), .wr_start(wr_start), .wr_addr(wr_addr),
        .wr_len(wr_len), .wdat(wdat), .wdat_ready(wdat_ready), .wr_done(wr_done), .wr_err(wr_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Master-model logs and counters (written only by the master process).
    logic [31:0] rd_addr_log [64];
    logic [3:0]  rd_len_log  [64];
    logic [31:0] wr_addr_log [64];
    logic [3:0]  wr_len_log  [64];
    int rd_n = 0, wr_n = 0, wr_done_cnt = 0, done_rise = 0, done_wr_at = 0;
    int data_err = 0, wbeats = 0;
    bit m_stall = 1'b0, m_inj_rd_err = 1'b0, m_inj_wr_err = 1'b0;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        int          nb;
        int          b0, b1, b2;
        logic [31:0] rd0, rd1, wr0, wr1;
        bit          stall;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Zero-latency AXI master model; decides inputs at each negedge for the next posedge.
    initial begin : master
        bit rd_act, wr_act, ph, done_prev;
        int rd_idx, rd_tot, wr_idx, wr_tot;
        logic [31:0] rd_base;
        rd_act = 1'b0; wr_act = 1'b0; ph = 1'b0; done_prev = 1'b0;
        rd_idx = 0; rd_tot = 0; wr_idx = 0; wr_tot = 0; rd_base = 32'h0;
        rdat_valid = 1'b0; rd_done = 1'b0; rd_err = 1'b0; rdat = 32'h0;
        wdat_ready = 1'b0; wr_done = 1'b0; wr_err = 1'b0;
        forever begin
            @(negedge clk);
            rdat_valid = 1'b0; rd_done = 1'b0; rd_err = 1'b0; rdat = 32'h0;
            wdat_ready = 1'b0; wr_done = 1'b0; wr_err = 1'b0;
            ph = ~ph;
            if (rst) begin
                rd_act = 1'b0; wr_act = 1'b0; done_prev = 1'b0;
            end else begin
                if (done_irq && !done_prev) begin
                    done_rise++;
                    done_wr_at = wr_done_cnt;
                end
                done_prev = done_irq;
                if (rd_start) begin
                    if (rd_n < 64) begin
                        rd_addr_log[rd_n] = rd_addr;
                        rd_len_log[rd_n]  = rd_len;
                    end
                    rd_n++;
                    rd_act = 1'b1; rd_base = rd_addr; rd_tot = 32'(rd_len) + 1; rd_idx = 0;
                end else if (rd_act && !(m_stall && ph)) begin
                    rdat_valid = 1'b1;
                    rdat = (rd_base + 32'(4 * rd_idx)) ^ KEY;
                    if (rd_idx == rd_tot - 1) begin
                        rd_done = 1'b1; rd_err = m_inj_rd_err; rd_act = 1'b0;
                    end
                    rd_idx++;
                end
                if (wr_start) begin
                    if (wr_n < 64) begin
                        wr_addr_log[wr_n] = wr_addr;
                        wr_len_log[wr_n]  = wr_len;
                    end
                    wr_n++;
                    wr_act = 1'b1; wr_tot = 32'(wr_len) + 1; wr_idx = 0;
                end else if (wr_act && !(m_stall && ph)) begin
                    if (wr_idx < wr_tot) begin
                        wdat_ready = 1'b1;
                        if (wdat !== ((rd_base + 32'(4 * wr_idx)) ^ KEY)) data_err++;
                        wbeats++;
                        wr_idx++;
                    end else begin
                        wr_done = 1'b1; wr_err = m_inj_wr_err; wr_act = 1'b0;
                        wr_done_cnt++;
                    end
                end
            end
        end
    end

    task automatic pulse_irq_clr();
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
    endtask

    task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        cfg_src = s; cfg_dst = d; cfg_len = l; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cyc;
        cyc = 0;
        while (!done_irq && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_done_timeout"}, 32'(done_irq), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int r0, w0, d0, e0, wb0, wd0;
        int eb [3];
        eb[0] = v.b0; eb[1] = v.b1; eb[2] = v.b2;
        pulse_irq_clr();
        r0 = rd_n; w0 = wr_n; d0 = done_rise; e0 = data_err; wb0 = wbeats; wd0 = wr_done_cnt;
        m_stall = v.stall;
        start_copy(v.src, v.dst, v.len);
        check({tag, "_busy_set"}, 32'(busy), 32'd1);
        wait_done(tag);
        repeat (4) @(negedge clk);
        check({tag, "_rd_bursts"}, 32'(rd_n - r0), 32'(v.nb));
        check({tag, "_wr_bursts"}, 32'(wr_n - w0), 32'(v.nb));
        for (int k = 0; k < v.nb && k < 3; k++) begin
            check($sformatf("%s_rd_len%0d", tag, k), 32'(rd_len_log[r0 + k]), 32'(eb[k] - 1));
            check($sformatf("%s_wr_len%0d", tag, k), 32'(wr_len_log[w0 + k]), 32'(eb[k] - 1));
        end
        check({tag, "_rd_addr0"}, rd_addr_log[r0], v.rd0);
        check({tag, "_wr_addr0"}, wr_addr_log[w0], v.wr0);
        if (v.nb > 1) begin
            check({tag, "_rd_addr1"}, rd_addr_log[r0 + 1], v.rd1);
            check({tag, "_wr_addr1"}, wr_addr_log[w0 + 1], v.wr1);
        end
        check({tag, "_data_errs"}, 32'(data_err - e0), 32'd0);
        check({tag, "_wbeats"}, 32'(wbeats - wb0), 32'(v.len));
        check({tag, "_done_once"}, 32'(done_rise - d0), 32'd1);
        check({tag, "_done_after_last_wr"}, 32'(done_wr_at - wd0), 32'(v.nb));
        check({tag, "_busy_clr"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        m_stall = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_irq"}, 32'(done_irq), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_rd_start"}, 32'(rd_start), 32'd0);
        check({tag, "_rd_addr"}, rd_addr, 32'd0);
        check({tag, "_rd_len"}, 32'(rd_len), 32'd0);
        check({tag, "_wr_start"}, 32'(wr_start), 32'd0);
        check({tag, "_wr_addr"}, wr_addr, 32'd0);
        check({tag, "_wr_len"}, 32'(wr_len), 32'd0);
        check({tag, "_wdat"}, wdat, 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs [6];
        int r0, w0, wb0;
        vecs[0] = '{32'h1000_0000, 32'h2000_0000, 16'd8,  1, 8, 0, 0,
                    32'h1000_0000, 32'h0,         32'h2000_0000, 32'h0,         1'b0};
        vecs[1] = '{32'h1000_0FF0, 32'h2000_0000, 16'd10, 2, 4, 6, 0,
                    32'h1000_0FF0, 32'h1000_1000, 32'h2000_0000, 32'h2000_0010, 1'b1};
        vecs[2] = '{32'h1100_0000, 32'h2200_0000, 16'd40, 3, 16, 16, 8,
                    32'h1100_0000, 32'h1100_0040, 32'h2200_0000, 32'h2200_0040, 1'b0};
        vecs[3] = '{32'h0000_0100, 32'h3000_0FF8, 16'd5,  2, 2, 3, 0,
                    32'h0000_0100, 32'h0000_0108, 32'h3000_0FF8, 32'h3000_1000, 1'b1};
        vecs[4] = '{32'h1000_0003, 32'h2000_0006, 16'd1,  1, 1, 0, 0,
                    32'h1000_0000, 32'h0,         32'h2000_0004, 32'h0,         1'b0};
        vecs[5] = '{32'hFFFF_FFF8, 32'h0000_0000, 16'd4,  2, 2, 2, 0,
                    32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0000, 32'h0000_0008, 1'b0};

        rst = 1'b1; cfg_start = 1'b0; irq_clr = 1'b0;
        cfg_src = 32'h0; cfg_dst = 32'h0; cfg_len = 16'h0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Zero-length copy; irq_clr during the DONE cycle loses to the set.
        pulse_irq_clr();
        r0 = rd_n; w0 = wr_n;
        cfg_src = 32'h1234_0000; cfg_dst = 32'h5678_0000; cfg_len = 16'd0; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("len0_irq_one_cycle", 32'(done_irq), 32'd0);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check("len0_irq_two_cycles", 32'(done_irq), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("len0_no_rd", 32'(rd_n - r0), 32'd0);
        check("len0_no_wr", 32'(wr_n - w0), 32'd0);
        pulse_irq_clr();
        check("len0_irq_clr", 32'(done_irq), 32'd0);

        // A second start during a running copy is ignored.
        r0 = rd_n; wb0 = wbeats;
        start_copy(32'h4000_0000, 32'h4100_0000, 16'd8);
        repeat (3) @(negedge clk);
        start_copy(32'h5000_0000, 32'h5100_0000, 16'd4);
        wait_done("restart");
        repeat (6) @(negedge clk);
        check("restart_rd_bursts", 32'(rd_n - r0), 32'd1);
        check("restart_rd_addr", rd_addr_log[r0], 32'h4000_0000);
        check("restart_rd_len", 32'(rd_len_log[r0]), 32'd7);
        check("restart_wbeats", 32'(wbeats - wb0), 32'd8);

        // Reset while reading a 16-beat burst, then a fresh 4-word copy.
        pulse_irq_clr();
        r0 = rd_n;
        start_copy(32'h6000_0000, 32'h7000_0000, 16'd16);
        for (int c = 0; c < 50 && rd_n == r0; c++) @(negedge clk);
        check("rstmid_rd_seen", 32'(rd_n - r0), 32'd1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rstmid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec('{32'h6000_0100, 32'h7000_0100, 16'd4, 1, 4, 0, 0,
                  32'h6000_0100, 32'h0, 32'h7000_0100, 32'h0, 1'b0}, "after_rst");

`ifdef DMA_RESP_ERR_EN
        pulse_irq_clr();
        r0 = rd_n; w0 = wr_n;
        m_inj_rd_err = 1'b1;
        start_copy(32'h0800_0000, 32'h0900_0000, 16'd20);
        wait_done("rderr");
        repeat (4) @(negedge clk);
        m_inj_rd_err = 1'b0;
        check("rderr_rd_bursts", 32'(rd_n - r0), 32'd1);
        check("rderr_no_wr", 32'(wr_n - w0), 32'd0);
        check("rderr_err", 32'(err), 32'd1);
        check("rderr_irq", 32'(done_irq), 32'd1);
        pulse_irq_clr();
        check("rderr_err_clr", 32'(err), 32'd0);
        check("rderr_irq_clr", 32'(done_irq), 32'd0);
        r0 = rd_n; w0 = wr_n;
        m_inj_wr_err = 1'b1;
        start_copy(32'h0800_0000, 32'h0900_0000, 16'd20);
        wait_done("wrerr");
        repeat (4) @(negedge clk);
        m_inj_wr_err = 1'b0;
        check("wrerr_rd_bursts", 32'(rd_n - r0), 32'd1);
        check("wrerr_wr_bursts", 32'(wr_n - w0), 32'd1);
        check("wrerr_err", 32'(err), 32'd1);
`else
        m_inj_rd_err = 1'b1;
        m_inj_wr_err = 1'b1;
        run_vec('{32'h0800_0000, 32'h0900_0000, 16'd20, 2, 16, 4, 0,
                  32'h0800_0000, 32'h0800_0040, 32'h0900_0000, 32'h0900_0040, 1'b0}, "resp_err_ignored");
        m_inj_rd_err = 1'b0;
        m_inj_wr_err = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
